// File: rtl/ceas_cascada_param_if.sv
// Bus bundle for ceas_cascada_param: run/load controls, time set values,
// current time and status pulses. Alarm signals exist only when the
// CEAS_ALARM_EN macro is defined.
interface ceas_cascada_param_if #(
    parameter int unsigned W = 6
);
    logic         enable;
    logic         load;
    logic [W-1:0] set_ora;
    logic [W-1:0] set_min;
    logic [W-1:0] set_sec;
    logic [W-1:0] ora_q;
    logic [W-1:0] minut_q;
    logic [W-1:0] secunda_q;
    logic         tick_1hz;
    logic         day_carry;
    logic         load_err;
`ifdef CEAS_ALARM_EN
    logic         alarm_set;
    logic [W-1:0] alarm_ora;
    logic [W-1:0] alarm_min;
    logic         alarm_ack;
    logic         alarm_q;

    modport master (
        output enable, load, set_ora, set_min, set_sec,
        output alarm_set, alarm_ora, alarm_min, alarm_ack,
        input  ora_q, minut_q, secunda_q, tick_1hz, day_carry, load_err, alarm_q
    );
    modport slave (
        input  enable, load, set_ora, set_min, set_sec,
        input  alarm_set, alarm_ora, alarm_min, alarm_ack,
        output ora_q, minut_q, secunda_q, tick_1hz, day_carry, load_err, alarm_q
    );
`else
    modport master (
        output enable, load, set_ora, set_min, set_sec,
        input  ora_q, minut_q, secunda_q, tick_1hz, day_carry, load_err
    );
    modport slave (
        input  enable, load, set_ora, set_min, set_sec,
        output ora_q, minut_q, secunda_q, tick_1hz, day_carry, load_err
    );
`endif
endinterface

// File: rtl/ceas_cascada_param.sv
// Parametrised hh:mm:ss cascade counter with internal prescaler, range-checked
// load and day-rollover pulse. Optional alarm comparator enabled by defining
// the CEAS_ALARM_EN macro.
module ceas_cascada_param #(
    parameter int unsigned DIV      = 50_000_000,
    parameter int unsigned HOUR_MOD = 24,
    parameter int unsigned W        = 6
) (
    input logic                  clk,
    input logic                  rst,
    ceas_cascada_param_if.slave  bus
);
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [W-1:0]  SIX_MAX   = W'(59);
    localparam logic [W-1:0]  HOUR_MAX  = W'(HOUR_MOD - 1);
    localparam logic [W-1:0]  HOUR_LIM  = W'(HOUR_MOD);

    logic [PW-1:0] presc;
    logic [W-1:0]  ora, minut, secunda;
    logic          tick_1hz, day_carry, load_err;

    logic          tick_adv, load_ok, load_bad, alarm_bad;
    logic          sec_wrap, min_wrap, hour_wrap, wrap_day;
    logic [W-1:0]  sec_nx, min_nx, ora_nx;

    // Tick qualification, load range check and the next cascade value
    always_comb begin
        tick_adv  = bus.enable && (presc == PRESC_MAX) && !bus.load;
        load_ok   = (bus.set_ora < HOUR_LIM) && (bus.set_min <= SIX_MAX) &&
                    (bus.set_sec <= SIX_MAX);
        load_bad  = bus.load && !load_ok;
        sec_wrap  = (secunda == SIX_MAX);
        min_wrap  = (minut == SIX_MAX);
        hour_wrap = (ora == HOUR_MAX);
        wrap_day  = sec_wrap && min_wrap && hour_wrap;
        sec_nx    = sec_wrap ? '0 : secunda + W'(1);
        min_nx    = minut;
        ora_nx    = ora;
        if (sec_wrap) begin
            min_nx = min_wrap ? '0 : minut + W'(1);
            if (min_wrap) begin
                ora_nx = hour_wrap ? '0 : ora + W'(1);
            end
        end
    end

    // Prescaler, time fields and status pulses; load outranks tick and enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            ora       <= '0;
            minut     <= '0;
            secunda   <= '0;
            tick_1hz  <= 1'b0;
            day_carry <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            tick_1hz  <= 1'b0;
            day_carry <= 1'b0;
            load_err  <= load_bad || alarm_bad;
            if (bus.load && load_ok) begin
                ora     <= bus.set_ora;
                minut   <= bus.set_min;
                secunda <= bus.set_sec;
                presc   <= '0;
            end else if (bus.enable) begin
                if (presc == PRESC_MAX) begin
                    // A rejected load on a tick edge still swallows the tick
                    presc <= '0;
                    if (tick_adv) begin
                        secunda   <= sec_nx;
                        minut     <= min_nx;
                        ora       <= ora_nx;
                        tick_1hz  <= 1'b1;
                        day_carry <= wrap_day;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign bus.ora_q     = ora;
    assign bus.minut_q   = minut;
    assign bus.secunda_q = secunda;
    assign bus.tick_1hz  = tick_1hz;
    assign bus.day_carry = day_carry;
    assign bus.load_err  = load_err;

`ifdef CEAS_ALARM_EN
    logic [W-1:0] al_ora, al_min;
    logic         alarm_q, alarm_ok, alarm_hit;

    // Alarm set range check and match on a tick landing on al_ora:al_min:00
    always_comb begin
        alarm_ok  = (bus.alarm_ora < HOUR_LIM) && (bus.alarm_min <= SIX_MAX);
        alarm_bad = bus.alarm_set && !alarm_ok;
        alarm_hit = tick_adv && sec_wrap && (min_nx == al_min) && (ora_nx == al_ora);
    end

    // Alarm registers and sticky alarm flag; a hit beats an ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_ora  <= '0;
            al_min  <= '0;
            alarm_q <= 1'b0;
        end else begin
            if (bus.alarm_set && alarm_ok) begin
                al_ora <= bus.alarm_ora;
                al_min <= bus.alarm_min;
            end
            if (alarm_hit) begin
                alarm_q <= 1'b1;
            end else if (bus.alarm_ack) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign bus.alarm_q = alarm_q;
`else
    assign alarm_bad = 1'b0;
`endif

endmodule

// File: doc/ceas_cascada_param.md
# ceas_cascada_param

Parametrised cascaded time-of-day counter (seconds/minutes/hours) with an internal prescaler, range-checked time load and a day-rollover carry. Successor to the fixed 6-bit cascade counter: the hour modulus and clock divider are configurable, and illegal loads are rejected. It sits between the board clock and the display/BCD conversion logic of the clock design. An optional alarm comparator is available at compile time.

## Interface

- `DIV`, 50_000_000: clk cycles per second tick; legal range ≥ 1.
- `HOUR_MOD`, 24: hour modulus; legal values 12 or 24; hours count 0..HOUR_MOD-1.
- `W`, 6: width of every time field; must hold 59 and HOUR_MOD-1.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `enable`  in  1: run; low freezes the prescaler and all time fields.
- `load`  in  1: one-cycle request to load `set_ora`/`set_min`/`set_sec`.
- `set_ora`  in  W: hour to load.
- `set_min`  in  W: minute to load.
- `set_sec`  in  W: second to load.
- `ora_q`  out  W: current hour.
- `minut_q`  out  W: current minute.
- `secunda_q`  out  W: current second.
- `tick_1hz`  out  1: one-cycle pulse on the cycle a second increment is applied.
- `day_carry`  out  1: one-cycle pulse when time wraps from HOUR_MOD-1:59:59 to 0:00:00.
- `load_err`  out  1: one-cycle pulse when a load is rejected.
- `alarm_set`, `alarm_ora` (W), `alarm_min` (W), `alarm_ack` in; `alarm_q` out 1. Present only with `CEAS_ALARM_EN`.

## Operation

- Prescaler `presc` counts 0..DIV-1 while `enable`=1; it holds while `enable`=0. The tick is internal: `presc`==DIV-1 and `enable`=1. On a tick, `presc` returns to 0.
- On a tick the cascade advances:
  - `secunda_q` increments if < 59, else goes to 0 with a carry to the minutes.
  - On that carry, `minut_q` increments if < 59, else goes to 0 with a carry to the hours.
  - On that carry, `ora_q` increments if < HOUR_MOD-1, else goes to 0 and `day_carry` pulses.
- Load has priority over tick and enable, and works with `enable`=0.
  - Legal load (`set_ora`<HOUR_MOD, `set_min`≤59, `set_sec`≤59): all three fields take the set values and `presc` clears to 0.
  - Illegal load: no field changes, `presc` is unaffected (keeps counting if enabled) and `load_err` pulses.
- Fields that are out of range cannot arise; the counter never leaves the legal space.
- Registered outputs reset to 0: `ora_q`, `minut_q`, `secunda_q`, `presc`, `tick_1hz`, `day_carry`, `load_err`, `alarm_q`.
- Asserting `rst` mid-count clears everything immediately. Counting resumes from 00:00:00 with a full DIV cycles before the first tick.

## Timing

- All outputs are registered. A field update is visible on the edge where the tick or load is sampled; load latency is 1 cycle.
- `tick_1hz`, `day_carry` and `load_err` are high for exactly the one cycle following the causing edge, aligned with the new field values.
- With `enable` held high, the first tick after reset occurs DIV cycles after reset release, and every DIV cycles thereafter.
- `load` and tick on the same edge: the load wins, and the tick is discarded for both legal and illegal loads.
- A legal load restarts the second: the next tick comes DIV cycles later.

## Configuration

- `CEAS_ALARM_EN` defined: alarm registers `al_ora`/`al_min` (reset 0) load from `alarm_ora`/`alarm_min` on `alarm_set`.
  - Alarm set values are range-checked like `load`; illegal values pulse `load_err` and leave the registers unchanged.
  - `alarm_q` sets (sticky) on the cycle the cascade reaches `al_ora`:`al_min`:00 by tick. Reaching that time by load does not set it.
  - `alarm_ack` clears `alarm_q`. Ack and set on the same edge: set wins.
- `CEAS_ALARM_EN` undefined: the alarm ports and logic are absent, with no other behavioural change.

## Test plan

- DIV=4, HOUR_MOD=24, enable=1 from reset: ticks at cycles 4, 8, 12; `secunda_q` reads 1, 2, 3; `tick_1hz` pulses once per tick.
- Load 23:59:58, run two ticks: time reads 23:59:59, then 00:00:00; `day_carry` pulses once, on the wrap.
- HOUR_MOD=12: load 11:59:59, one tick → 00:00:00 with `day_carry`=1. Load `set_ora`=12 → `load_err`=1 and time unchanged.
- Load 10:60:00 → `load_err` pulse, fields hold. Load asserted on a tick cycle with legal 05:06:07 → reads 05:06:07, next tick 4 cycles later.
- `enable`=0 for 10 cycles mid-count (`presc`=2): fields and `presc` frozen. After re-enable, the tick arrives 2 cycles later. `rst` pulse mid-count → all outputs 0 immediately.
- `CEAS_ALARM_EN`: alarm 00:01, load 00:00:58, two ticks → `alarm_q`=1 at 00:01:00 and stays high; `alarm_ack` → 0.
